alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Sequential execute stage ahead of the flag control unit. Accepts one operation per start
//  pulse. Logic and add/sub ops complete in 1 cycle; DIV (4'b0011) runs a 16-iteration
//  restoring divider. Drives result, carry_out, opcode and src2 to the flag control unit,
//  which derives the zero, carry and div-done flags.
// PARAMETERS
//  WIDTH     16   operand/result width; DIV iteration count equals WIDTH
//  CNT_W     5    iteration counter width; must hold WIDTH (clog2(WIDTH)+1)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; accepted only when busy==0
//  opcode     in   4      operation code, captured on accept
//  src1       in   WIDTH  operand A / dividend, captured on accept
//  src2       in   WIDTH  operand B / divisor, captured on accept
//  busy       out  1      DIV in progress; start ignored
//  out_valid  out  1      one-cycle pulse: result/carry_out/remainder valid
//  result     out  WIDTH  result or quotient; held until next completion
//  remainder  out  WIDTH  DIV remainder, 0 for other ops; held
//  carry_out  out  1      carry/borrow/shifted-out bit; held
//  op_out     out  4      opcode of the completed op (flag-unit opcode input)
//  src2_out   out  WIDTH  captured src2 of the completed op (flag-unit src2 input)
//  div_by_zero out 1      pulse with out_valid when DIV had src2==0
// BEHAVIOUR
//  Reset: every output 0, FSM to IDLE, counter 0. Reset overrides start and aborts any DIV.
//    No out_valid is produced for the aborted op.
//  Accept: start && !busy in cycle N latches opcode/src1/src2.
//  Opcodes:
//    0000 ADD  {carry,result} = src1+src2
//    0001 SUB  result = src1-src2, carry = borrow (src1<src2)
//    0010 AND
//    0011 DIV
//    0100 OR
//    0101 XOR
//    0110 SHL  by 1, carry = src1[MSB]
//    0111 SHR  logical by 1, carry = src1[0]
//    1000-1111 undefined: result 0, carry 0, out_valid still pulses
//  Single-cycle ops: registered; out_valid=1 in N+1; busy stays 0.
//  AND/OR/XOR/DIV: carry_out=0.
//  DIV, src2!=0: FSM IDLE->DIV. busy=1 in N+1..N+WIDTH.
//    Each cycle does one restoring step: shift {rem,quot} left, subtract divisor,
//    restore if negative, quotient bit = !negative.
//    Counter counts WIDTH..1. At 1 -> IDLE.
//    out_valid=1 and busy=0 in N+WIDTH+1; result=quotient, remainder=rem.
//  DIV, src2==0: no iteration. In N+1: out_valid=1, div_by_zero=1, result={WIDTH{1'b1}},
//    remainder=src1.
//  start while busy: ignored, not queued. start in the out_valid cycle (busy=0) is accepted.
//  Outputs result/remainder/carry_out/op_out/src2_out change only on a completion edge;
//    out_valid/div_by_zero are 0 otherwise.
//  Width: all arithmetic is unsigned WIDTH-bit. ADD/SUB use a WIDTH+1-bit internal sum.
// STRUCTURE
//  Shared include alu_defs.vh: opcode localparams (OP_ADD..OP_SHR, OP_DIV=4'b0011),
//    FSM state encodings S_IDLE/S_DIV.
//  One sub-module: div_iter_core.
//    Inputs: load/step, dividend, divisor.
//    Outputs: quotient, remainder.
//    Holds the rem/quot shift registers and one subtractor.
//    Top holds the FSM, counter and output registers.
// TESTING
//  ADD 16'hFFFF+16'h0001 -> out_valid next cycle, result 0000, carry_out 1, busy never 1
//  SUB 16'h0003-16'h0005 -> result FFFE, carry_out 1; SHL 16'h8001 -> result 0002, carry 1
//  DIV 16'd1000/16'd7 at cycle N -> busy N+1..N+16, out_valid N+17, result 142, remainder 6,
//    op_out 0011
//  DIV 16'h1234/0 -> out_valid+div_by_zero next cycle, result FFFF, remainder 1234,
//    busy stays 0
//  start ADD during DIV busy -> ignored; DIV result unaffected; no extra out_valid
//  rst at iteration 8 of DIV -> all outputs 0 next cycle, no out_valid; fresh DIV 9/3 -> 3 r0

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared constants for the execute stage: the opcode map seen by the flag
// control unit and the two FSM state encodings of the top-level sequencer.
// No ports; imported by alu_exec_unit.
// -----------------------------------------------------------------------------
package alu_exec_unit_pkg;

    // Opcode map. DIV sits at 4'b0011; 4'b1000..4'b1111 are undefined and
    // complete in one cycle with a zero result.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;

    // Sequencer states.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DIV  = 1'b1;

endpackage

// File: rtl/div_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
// Restoring divider datapath: remainder/quotient shift registers plus one
// subtractor. Sequencing (iteration count, completion) lives in the parent.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   i_load       in   capture dividend/divisor, clear partial remainder
//   i_step       in   perform one restoring iteration
//   i_dividend   in   WIDTH  dividend
//   i_divisor    in   WIDTH  divisor (non-zero when stepping)
//   o_quotient   out  WIDTH  quotient as it will be after the current step
//   o_remainder  out  WIDTH  remainder as it will be after the current step
//
// The outputs are the post-step values so the parent can capture the final
// quotient/remainder on the same edge that performs the last iteration.
// -----------------------------------------------------------------------------
module div_iter_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;

    logic [WIDTH:0]   w_shifted;
    logic             w_neg;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quot_step;

    // Shift the next dividend bit into the partial remainder. The shifted
    // value needs WIDTH+1 bits; the trial subtraction is negative exactly
    // when it is below the divisor, in which case the shifted value is kept
    // (restore). Either way the surviving remainder fits in WIDTH bits, so
    // the low-WIDTH-bit subtraction is exact.
    assign w_shifted   = {r_rem, r_quot[WIDTH-1]};
    assign w_neg       = (w_shifted < {1'b0, r_divisor});
    assign w_rem_step  = w_neg ? w_shifted[WIDTH-1:0]
                               : (w_shifted[WIDTH-1:0] - r_divisor);
    assign w_quot_step = {r_quot[WIDTH-2:0], ~w_neg};

    assign o_quotient  = w_quot_step;
    assign o_remainder = w_rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_rem     <= w_rem_step;
            r_quot    <= w_quot_step;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Sequential execute stage feeding the flag control unit. One operation is
// accepted per start pulse while idle. Logic, add/sub and shift ops finish
// in one cycle; DIV runs WIDTH restoring iterations in div_iter_core.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset (aborts a running DIV)
//   start        in   request, accepted only when busy==0
//   opcode       in   4      operation code
//   src1         in   WIDTH  operand A / dividend
//   src2         in   WIDTH  operand B / divisor
//   busy         out  DIV in progress; start ignored
//   out_valid    out  one-cycle completion pulse
//   result       out  WIDTH  result or quotient (held)
//   remainder    out  WIDTH  DIV remainder, 0 for other ops (held)
//   carry_out    out  carry / borrow / shifted-out bit (held)
//   op_out       out  4      opcode of the completed op (held)
//   src2_out     out  WIDTH  src2 of the completed op (held)
//   div_by_zero  out  pulse with out_valid when DIV had src2==0
// -----------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carry_out,
    output logic [3:0]       op_out,
    output logic [WIDTH-1:0] src2_out,
    output logic             div_by_zero
);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_src2;
    logic             r_valid;
    logic             r_dbz;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_rem;
    logic             r_carry;
    logic [3:0]       r_op_out;
    logic [WIDTH-1:0] r_src2_out;

    logic             w_is_div;
    logic             w_div_zero;
    logic             w_div_load;
    logic             w_div_step;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_is_div   = (opcode == OP_DIV);
    assign w_div_zero = (src2 == '0);
    assign w_div_load = start && (r_state == S_IDLE) && w_is_div && !w_div_zero;
    assign w_div_step = (r_state == S_DIV);

    // WIDTH+1-bit add/sub: the top bit is the carry for ADD and the borrow
    // for SUB (a wrapped difference sets it exactly when src1 < src2).
    assign w_sum  = {1'b0, src1} + {1'b0, src2};
    assign w_diff = {1'b0, src1} - {1'b0, src2};

    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        case (opcode)
            OP_ADD: {w_alu_carry, w_alu_result} = w_sum;
            OP_SUB: {w_alu_carry, w_alu_result} = w_diff;
            OP_AND: w_alu_result = src1 & src2;
            OP_OR:  w_alu_result = src1 | src2;
            OP_XOR: w_alu_result = src1 ^ src2;
            OP_SHL: {w_alu_carry, w_alu_result} = {src1, 1'b0};
            OP_SHR: {w_alu_result, w_alu_carry} = {1'b0, src1};
            default: begin
                // DIV is handled by the sequencer; 1xxx opcodes yield zero.
                w_alu_result = '0;
                w_alu_carry  = 1'b0;
            end
        endcase
    end

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_div_load),
        .i_step      (w_div_step),
        .i_dividend  (src1),
        .i_divisor   (src2),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div_src2 <= '0;
            r_valid    <= 1'b0;
            r_dbz      <= 1'b0;
            r_result   <= '0;
            r_rem      <= '0;
            r_carry    <= 1'b0;
            r_op_out   <= '0;
            r_src2_out <= '0;
        end else begin
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_div && !w_div_zero) begin
                            // Iterations run in the WIDTH cycles after accept.
                            r_state    <= S_DIV;
                            r_cnt      <= CNT_W'(WIDTH);
                            r_div_src2 <= src2;
                        end else begin
                            r_valid    <= 1'b1;
                            r_op_out   <= opcode;
                            r_src2_out <= src2;
                            if (w_is_div) begin
                                // Divide by zero: all-ones quotient, dividend
                                // passed through as the remainder.
                                r_dbz    <= 1'b1;
                                r_result <= '1;
                                r_rem    <= src1;
                                r_carry  <= 1'b0;
                            end else begin
                                r_result <= w_alu_result;
                                r_rem    <= '0;
                                r_carry  <= w_alu_carry;
                            end
                        end
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        // Last iteration: capture the post-step core values.
                        r_state    <= S_IDLE;
                        r_valid    <= 1'b1;
                        r_result   <= w_quot;
                        r_rem      <= w_rem;
                        r_carry    <= 1'b0;
                        r_op_out   <= OP_DIV;
                        r_src2_out <= r_div_src2;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_DIV);
    assign out_valid   = r_valid;
    assign div_by_zero = r_dbz;
    assign result      = r_result;
    assign remainder   = r_rem;
    assign carry_out   = r_carry;
    assign op_out      = r_op_out;
    assign src2_out    = r_src2_out;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: a cycle-level behavioural model
// (plain arithmetic, a single pending-completion record) is compared against
// the DUT on every falling edge, with directed cases and a random phase.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        busy;
    logic        out_valid;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        carry_out;
    logic [3:0]  op_out;
    logic [15:0] src2_out;
    logic        div_by_zero;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opcode      (opcode),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .out_valid   (out_valid),
        .result      (result),
        .remainder   (remainder),
        .carry_out   (carry_out),
        .op_out      (op_out),
        .src2_out    (src2_out),
        .div_by_zero (div_by_zero)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        e_busy, e_valid, e_dbz, e_carry;
    logic [15:0] e_result, e_rem, e_src2;
    logic [3:0]  e_op;
    bit          pend_active = 1'b0;
    int          pend_left   = 0;
    logic [15:0] p_quot, p_rem, p_src2;

    function automatic void model_single(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, output logic [15:0] r,
                                         output logic c);
        int unsigned ai = a;
        int unsigned bi = b;
        r = 16'h0;
        c = 1'b0;
        case (op)
            4'd0: begin r = 16'((ai + bi) % 65536); c = (ai + bi) > 65535; end
            4'd1: begin r = 16'((ai + 65536 - bi) % 65536); c = ai < bi; end
            4'd2: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = 16'((ai * 2) % 65536); c = ai >= 32768; end
            4'd7: begin r = 16'(ai / 2); c = (ai % 2) == 1; end
            default: begin r = 16'h0; c = 1'b0; end
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [15:0] r;
        logic        c;
        if (rst) begin
            e_busy = 0; e_valid = 0; e_dbz = 0; e_carry = 0;
            e_result = 0; e_rem = 0; e_src2 = 0; e_op = 0;
            pend_active = 0;
        end else begin
            e_valid = 0;
            e_dbz   = 0;
            if (pend_active) begin
                // A divide is running: start is ignored this cycle.
                pend_left--;
                if (pend_left == 0) begin
                    pend_active = 0;
                    e_valid = 1; e_result = p_quot; e_rem = p_rem;
                    e_carry = 0; e_op = 4'd3; e_src2 = p_src2;
                end
            end else if (start) begin
                if (opcode == 4'd3 && src2 != 0) begin
                    pend_active = 1;
                    pend_left   = 16;
                    p_quot = src1 / src2;
                    p_rem  = src1 % src2;
                    p_src2 = src2;
                end else if (opcode == 4'd3) begin
                    e_valid = 1; e_dbz = 1; e_result = 16'hFFFF; e_rem = src1;
                    e_carry = 0; e_op = opcode; e_src2 = src2;
                end else begin
                    model_single(opcode, src1, src2, r, c);
                    e_valid = 1; e_result = r; e_rem = 0;
                    e_carry = c; e_op = opcode; e_src2 = src2;
                end
            end
            e_busy = pend_active;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",        32'(busy),        32'(e_busy));
            chk("out_valid",   32'(out_valid),   32'(e_valid));
            chk("div_by_zero", 32'(div_by_zero), 32'(e_dbz));
            chk("result",      32'(result),      32'(e_result));
            chk("remainder",   32'(remainder),   32'(e_rem));
            chk("carry_out",   32'(carry_out),   32'(e_carry));
            chk("op_out",      32'(op_out),      32'(e_op));
            chk("src2_out",    32'(src2_out),    32'(e_src2));
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; opcode = op; src1 = a; src2 = b;
        $display("issue op=%0h a=%0h b=%0h t=%0t", op, a, b, $time);
        idle(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            idle(1);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: out_valid timeout after %0d cycles, expected a completion", name, max_cycles);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; opcode = 4'h0; src1 = 16'h0; src2 = 16'h0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        idle(1);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        rst = 1'b0;
        idle(1);

        // ADD with carry out
        issue(4'h0, 16'hFFFF, 16'h0001);
        chk("add_valid",  32'(out_valid), 32'h1);
        chk("add_result", 32'(result), 32'h0000);
        chk("add_carry",  32'(carry_out), 32'h1);
        chk("add_busy",   32'(busy), 32'h0);
        chk("model_add",  32'(e_result), 32'h0000);

        // SUB with borrow
        issue(4'h1, 16'h0003, 16'h0005);
        chk("sub_result", 32'(result), 32'hFFFE);
        chk("sub_borrow", 32'(carry_out), 32'h1);
        chk("model_sub",  32'(e_result), 32'hFFFE);

        // SHL shifting out the MSB
        issue(4'h6, 16'h8001, 16'h1111);
        chk("shl_result", 32'(result), 32'h0002);
        chk("shl_carry",  32'(carry_out), 32'h1);

        // DIV 1000/7: busy N+1..N+16, completion N+17
        issue(4'h3, 16'd1000, 16'd7);
        chk("div_busy_first", 32'(busy), 32'h1);
        idle(15);
        chk("div_busy_last",  32'(busy), 32'h1);
        chk("div_not_yet",    32'(out_valid), 32'h0);
        idle(1);
        chk("div_valid",  32'(out_valid), 32'h1);
        chk("div_quot",   32'(result), 32'd142);
        chk("div_rem",    32'(remainder), 32'd6);
        chk("div_op",     32'(op_out), 32'h3);
        chk("div_done_busy", 32'(busy), 32'h0);
        chk("model_div",  32'(e_result), 32'd142);

        // DIV by zero
        issue(4'h3, 16'h1234, 16'h0000);
        chk("dbz_valid",  32'(out_valid), 32'h1);
        chk("dbz_flag",   32'(div_by_zero), 32'h1);
        chk("dbz_result", 32'(result), 32'hFFFF);
        chk("dbz_rem",    32'(remainder), 32'h1234);
        chk("dbz_busy",   32'(busy), 32'h0);

        // start while busy is ignored
        issue(4'h3, 16'd50000, 16'd3);
        idle(3);
        issue(4'h0, 16'h0001, 16'h0002);
        wait_valid(20, "div_busy_start");
        chk("div2_quot", 32'(result), 32'd16666);
        chk("div2_rem",  32'(remainder), 32'd2);
        chk("div2_op",   32'(op_out), 32'h3);
        idle(3);

        // reset during iteration 8 aborts the divide
        issue(4'h3, 16'hABCD, 16'h0012);
        idle(7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_valid",  32'(out_valid), 32'h0);
        chk("abort_busy",   32'(busy), 32'h0);
        chk("abort_op",     32'(op_out), 32'h0);
        idle(20);
        issue(4'h3, 16'd9, 16'd3);
        idle(16);
        chk("div9_valid", 32'(out_valid), 32'h1);
        chk("div9_quot",  32'(result), 32'd3);
        chk("div9_rem",   32'(remainder), 32'd0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            start  = ($urandom_range(0, 2) == 0);
            opcode = ($urandom_range(0, 9) < 3) ? 4'h3 : 4'($urandom_range(0, 15));
            src1   = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                src2 = 16'h0;
            else if ($urandom_range(0, 1) == 1)
                src2 = 16'($urandom_range(1, 20));
            else
                src2 = 16'($urandom);
            idle(1);
        end
        rst = 1'b0;
        start = 1'b0;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
